// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for a VGA-style display. It produces horizontal and
//   vertical counters, registered sync and data-enable strobes, a pixel fetch
//   strobe that leads data-enable by RD_LEAD clocks, and the colour outputs.
//
//   Line and frame order: sync, back porch, active, front porch.
//
//   Optional feature: define VGA_TIMING_TPG_EN to build in an 8-bar colour
//   test-pattern generator, which is selected at run time by tpg_en. Without
//   the macro, tpg_en is accepted but has no effect.
//
// Ports
//   clk          in   pixel clock
//   rstn         in   synchronous active-low reset
//   sof_sync     in   frame restart; held high, it holds both counters at 0
//   rd_req       out  pixel fetch strobe, one pulse per active pixel
//   rd_data      in   pixel {B,G,R}, CW bits per channel
//   rd_valid     in   rd_data is valid in this cycle
//   red/grn/blu  out  colour channels; 0 outside the active area
//   hsync/vsync  out  sync strobes, asserted level HS_POL / VS_POL
//   de           out  data enable, high in the active area
//   hcount       out  horizontal position of the current cycle
//   vcount       out  vertical position of the current cycle
//   frame_start  out  one-clock pulse at hcount=0, vcount=0
//   line_start   out  one-clock pulse at hcount=0
//   underflow    out  sticky: rd_valid was low during a de cycle
//   tpg_en       in   selects the test pattern (macro build only)
//
// Pixel handshake: rd_req high in cycle n requests the pixel that is shown in
// cycle n+RD_LEAD. In that cycle the source presents it on rd_data with
// rd_valid=1. rd_valid=0 while de=1 blanks the pixel and sets underflow.
// RD_LEAD must lie in 1..H_BP. H_ACTIVE must be at least 8 when the pattern
// generator is built in.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 29,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 4,
   parameter int RD_LEAD  = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            sof_sync,
   output logic            rd_req,
   input  logic [3*CW-1:0] rd_data,
   input  logic            rd_valid,
   output logic [CW-1:0]   red,
   output logic [CW-1:0]   grn,
   output logic [CW-1:0]   blu,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic [11:0]     hcount,
   output logic [11:0]     vcount,
   output logic            frame_start,
   output logic            line_start,
   output logic            underflow,
   input  logic            tpg_en
);

   typedef logic [11:0] cnt_t;

   localparam int   H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int   V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_SYNC_E = cnt_t'(H_SYNC);
   localparam cnt_t V_SYNC_E = cnt_t'(V_SYNC);
   localparam cnt_t H_ACT_S  = cnt_t'(H_SYNC + H_BP);
   localparam cnt_t H_ACT_E  = cnt_t'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam cnt_t V_ACT_S  = cnt_t'(V_SYNC + V_BP);
   localparam cnt_t V_ACT_E  = cnt_t'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam cnt_t RD_S     = cnt_t'(H_SYNC + H_BP - RD_LEAD);
   localparam cnt_t RD_E     = cnt_t'(H_SYNC + H_BP + H_ACTIVE - 1 - RD_LEAD);

   cnt_t hcount_q, hcount_d;
   cnt_t vcount_q, vcount_d;
   // Restart pending: set by reset or sof_sync. The first free cycle after it
   // presents 0/0 again with frame_start, so counting resumes from a clean frame.
   logic pend_q, pend_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic de_q, de_d;
   logic rd_req_q, rd_req_d;
   logic fs_q, fs_d;
   logic ls_q, ls_d;
   logic underflow_q, underflow_d;
   logic h_act, v_act;
   logic [3*CW-1:0] pix;

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      pend_d   = 1'b0;
      if (sof_sync) begin
         hcount_d = '0;
         vcount_d = '0;
         pend_d   = 1'b1;
      end else if (pend_q) begin
         hcount_d = '0;
         vcount_d = '0;
      end else if (hcount_q == H_LAST) begin
         hcount_d = '0;
         vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 12'd1;
      end else begin
         hcount_d = hcount_q + 12'd1;
      end

      // Strobes are decoded from the next counter values so that, once
      // registered, they line up with the counters presented in the same cycle.
      h_act    = (hcount_d >= H_ACT_S) && (hcount_d <= H_ACT_E);
      v_act    = (vcount_d >= V_ACT_S) && (vcount_d <= V_ACT_E);
      hsync_d  = (hcount_d < H_SYNC_E) ? HS_POL : ~HS_POL;
      vsync_d  = (vcount_d < V_SYNC_E) ? VS_POL : ~VS_POL;
      de_d     = h_act && v_act;
      rd_req_d = v_act && (hcount_d >= RD_S) && (hcount_d <= RD_E);
      // While sof_sync holds the counters at 0 no frame or line has started yet.
      fs_d     = !sof_sync && (hcount_d == '0) && (vcount_d == '0);
      ls_d     = !sof_sync && (hcount_d == '0);

      underflow_d = fs_d ? 1'b0 : (underflow_q | (de_q & ~rd_valid));
`ifdef VGA_TIMING_TPG_EN
      if (tpg_en) underflow_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         hcount_q    <= '0;
         vcount_q    <= '0;
         pend_q      <= 1'b1;
         hsync_q     <= ~HS_POL;
         vsync_q     <= ~VS_POL;
         de_q        <= 1'b0;
         rd_req_q    <= 1'b0;
         fs_q        <= 1'b0;
         ls_q        <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         pend_q      <= pend_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         de_q        <= de_d;
         rd_req_q    <= rd_req_d;
         fs_q        <= fs_d;
         ls_q        <= ls_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef VGA_TIMING_TPG_EN
   localparam cnt_t BAR_W = cnt_t'(H_ACTIVE / 8);
   cnt_t       bar_off;
   logic [2:0] bar;
   assign bar_off = hcount_q - H_ACT_S;
   assign bar     = 3'(bar_off / BAR_W);
`else
   logic unused_tpg_en;
   assign unused_tpg_en = tpg_en;
`endif

   // Colour passes straight from rd_data in the de cycle that the source fills.
   always_comb begin
      pix = '0;
      if (de_q && rd_valid) pix = rd_data;
`ifdef VGA_TIMING_TPG_EN
      if (tpg_en) pix = de_q ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}} : '0;
`endif
   end

   assign red         = pix[CW-1:0];
   assign grn         = pix[2*CW-1:CW];
   assign blu         = pix[3*CW-1:2*CW];
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rd_req      = rd_req_q;
   assign frame_start = fs_q;
   assign line_start  = ls_q;
   assign underflow   = underflow_q;

endmodule
